// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-and-add multiplier.
package mul_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_w(input int nbit);
    return $clog2(nbit) + 1;
  endfunction
endpackage

// File: rtl/mul_shift_add_adder.sv
// n-bit ripple-carry adder used for the multiplier's accumulate step.
module mul_shift_add_adder #(
  parameter int nbit = 32
) (
  input  logic [nbit-1:0] x,
  input  logic [nbit-1:0] y,
  input  logic            cin,
  output logic [nbit-1:0] sum,
  output logic            cout
);
  logic cy;

  // Carry threads bit by bit, lsb first, exactly as a ripple chain would.
  always_comb begin
    cy  = cin;
    sum = '0;
    for (int i = 0; i < nbit; i++) begin
      sum[i] = x[i] ^ y[i] ^ cy;
      cy     = (x[i] & y[i]) | (cy & (x[i] ^ y[i]));
    end
    cout = cy;
  end
endmodule

// File: rtl/mul_shift_add.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int NBIT = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NBIT-1:0]   a,
  input  logic [NBIT-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*NBIT-1:0] p
);
  localparam int CW = cnt_w(NBIT);

  state_t              state, nstate;
  logic [NBIT-1:0]     m;
  logic [2*NBIT-1:0]   pr;
  logic [CW-1:0]       count;
  logic [NBIT-1:0]     sum;
  logic                cout;
  logic [2*NBIT-1:0]   pnxt;
  logic [2*NBIT-1:0]   pstep;
  logic                last;
  logic                fin;
  logic                load;

  mul_shift_add_adder #(.nbit(NBIT)) u_add (
    .x    (pr[2*NBIT-1:NBIT]),
    .y    (m),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Keep the adder carry as the new top bit; it is shifted down into P_hi.
  always_comb begin
    pnxt = pr[0] ? {cout, sum, pr[NBIT-1:1]}
                 : {1'b0, pr[2*NBIT-1:NBIT], pr[NBIT-1:1]};
    last = (count == CW'(NBIT-1));
  end

`ifdef MUL_EARLY_TERM_EN
  logic          lo_zero;
  logic [CW-1:0] rem;

  // Unprocessed multiplier bits sit in P_lo[NBIT-1-count:0]; shifting by
  // count drops the already-retired product bits above them.
  always_comb begin
    rem     = CW'(NBIT) - count;
    lo_zero = ((pr[NBIT-1:0] << count) == '0);
    pstep   = lo_zero ? (pr >> rem) : pnxt;
    fin     = last | lo_zero;
  end
`else
  always_comb begin
    pstep = pnxt;
    fin   = last;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start) nstate = RUN;
      RUN:     if (fin)   nstate = DONE;
      DONE:    nstate = start ? RUN : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    load = ((state == IDLE) || (state == DONE)) && start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m     <= '0;
      pr    <= '0;
      count <= '0;
    end else if (load) begin
      m     <= a;
      pr    <= {{NBIT{1'b0}}, b};
      count <= '0;
    end else if (state == RUN) begin
      pr    <= pstep;
      count <= count + 1'b1;
    end
  end

  assign p = pr;
endmodule

// File: tb/tb_mul_shift_add.sv
// Directed and randomized checks of mul_shift_add at NBIT=8 and NBIT=32.
module tb_mul_shift_add;
  logic        clk = 1'b0;
  logic        reset;
  logic        s8, s32;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy8, done8, busy32, done32;
  logic [15:0] p8;
  logic [63:0] p32;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mul_shift_add #(.NBIT(8)) dut8 (
    .clk(clk), .reset(reset), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8)
  );

  mul_shift_add #(.NBIT(32)) dut32 (
    .clk(clk), .reset(reset), .start(s32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .p(p32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycles from the start-driving negedge to the first done sample.
  function automatic int exp_lat(input int n, input logic [63:0] y);
    int bl = 0;
    for (int i = 0; i < n; i++) if (y[i]) bl = i + 1;
`ifdef MUL_EARLY_TERM_EN
    return (bl + 2 < n + 1) ? bl + 2 : n + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic launch(input bit sel, input logic [31:0] x, input logic [31:0] y);
    if (sel) begin s32 = 1'b1; a32 = x; b32 = y; end
    else     begin s8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; end
  endtask

  task automatic wait_done(input bit sel, input logic [31:0] x, input logic [31:0] y,
                           input bit mid);
    int k = 0, nbusy = 0, nviol = 0;
    bit seen = 0, d, bz;
    logic [63:0] obs;
    logic [63:0] e;
    e = 64'(x) * 64'(y);
    while (!seen && k < 80) begin
      @(negedge clk);
      k++;
      if (k == 1) begin s8 = 1'b0; s32 = 1'b0; end
      if (mid && k == 4) begin s8 = 1'b1; a8 = 8'd1; b8 = 8'd1; end
      if (mid && k == 5) s8 = 1'b0;
      d  = sel ? done32 : done8;
      bz = sel ? busy32 : busy8;
      if (d && bz) nviol++;
      if (bz) nbusy++;
      if (d) seen = 1;
    end
    obs = sel ? p32 : {48'd0, p8};
    chk("latency", 64'(k), 64'(exp_lat(sel ? 32 : 8, {32'd0, y})));
    chk("product", obs, e);
    chk("busy_cycles", 64'(nbusy), 64'(exp_lat(sel ? 32 : 8, {32'd0, y}) - 1));
    chk("done_and_busy", 64'(nviol), 64'd0);
  endtask

  task automatic after_done(input bit sel, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    chk("done_pulse", 64'(sel ? done32 : done8), 64'd0);
    chk("p_hold", sel ? p32 : {48'd0, p8}, 64'(x) * 64'(y));
  endtask

  task automatic op(input bit sel, input logic [31:0] x, input logic [31:0] y);
    launch(sel, x, y);
    wait_done(sel, x, y, 1'b0);
    after_done(sel, x, y);
  endtask

  initial begin
    int nd;
    logic [31:0] ra, rb;
    reset = 1'b1; s8 = 1'b0; s32 = 1'b0;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_p8", 64'(p8), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_p32", p32, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    op(0, 13, 11);
    op(0, 255, 255);
    op(0, 255, 128);
    op(0, 0, 200);
    op(0, 200, 0);
    op(0, 1, 255);
    op(0, 128, 1);

    // Mid-run start is ignored, then a start in the done cycle is taken.
    launch(0, 13, 11);
    wait_done(0, 13, 11, 1'b1);
    launch(0, 3, 5);
    wait_done(0, 3, 5, 1'b0);
    after_done(0, 3, 5);

    // Abort mid-run with reset.
    launch(0, 13, 11);
    @(negedge clk); s8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_p", 64'(p8), 64'd0);
    nd = 0;
    repeat (12) begin @(negedge clk); if (done8) nd++; end
    chk("abort_no_done", 64'(nd), 64'd0);
    op(0, 2, 3);

    op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(1, 32'h1234_5678, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 15))
        0:       rb = '0;
        1:       rb = rb >> $urandom_range(1, 31);
        2:       ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op(1, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
